// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb_pkg
// Description : Shared constants for the write-back arbiter. XLEN and REG_AW
//               defaults match the core's `RegBus / `RegAddrBus widths. The
//               channel index constants name the fixed producer channels.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

  // Default widths, kept equal to the core's register bus definitions
  localparam int WB_XLEN   = 32;  // `RegBus width
  localparam int WB_REG_AW = 5;   // `RegAddrBus width

  // Fixed channel assignments
  localparam int WB_CH_PIPE = 0;  // in-order pipeline (mem_wb)
  localparam int WB_CH_MDU  = 1;  // multi-cycle mul/div unit

  // Width of a round-robin pointer over n channels (never zero)
  function automatic int wb_ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : wb_arb_pkg
`default_nettype wire

// File: rtl/wb_arb_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb
// Description : Combinational round-robin arbiter. Searches the request vector
//               starting at index i_ptr, then ascending with wrap, and grants
//               the first requester found.
// Ports       : i_req      [NUM_CH] request vector
//               i_ptr      [PW]     search start index
//               o_grant    [NUM_CH] one-hot grant (all zero when no request)
//               o_next_ptr [PW]     (granted index + 1) mod NUM_CH, or i_ptr
//                                   when nothing is granted
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb #(
  parameter int NUM_CH = 2,
  parameter int PW     = 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [PW-1:0]     i_ptr,
  output logic [NUM_CH-1:0] o_grant,
  output logic [PW-1:0]     o_next_ptr
);

  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    o_grant    = '0;
    o_next_ptr = i_ptr;
    w_found    = 1'b0;
    w_idx      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = PW'((int'(i_ptr) + i) % NUM_CH);
      if (!w_found && i_req[w_idx]) begin
        w_found          = 1'b1;
        o_grant[w_idx]   = 1'b1;
        o_next_ptr       = PW'((int'(w_idx) + 1) % NUM_CH);
      end
    end
  end

endmodule : rr_arb
`default_nettype wire

// File: rtl/wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb
// Description : Multi-channel write-back arbiter. Each result channel has a
//               one-entry holding buffer with valid/ready handshake; buffered
//               results share the single register-file write port through
//               round-robin arbitration, and the port output is registered.
//               Writes to x0 are accepted and discarded.
// Macro       : WB_FWD_EN - adds the fwd_* forwarding view of the output
//               register.
// Ports       : clk, rst (async, active-high)
//               ch_valid_i/ch_ready_o   per-channel handshake
//               ch_rd_addr_i/ch_rd_data_i flattened per-channel address/data
//               regs_wen_o/rd_addr_o/rd_data_o registered write port
//               busy_o                   any holding buffer valid
//               fwd_valid_o/fwd_addr_o/fwd_data_o (WB_FWD_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arb
  import wb_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int XLEN   = WB_XLEN,
  parameter int REG_AW = WB_REG_AW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_valid_i,
  output logic [NUM_CH-1:0]        ch_ready_o,
  input  logic [NUM_CH*REG_AW-1:0] ch_rd_addr_i,
  input  logic [NUM_CH*XLEN-1:0]   ch_rd_data_i,
  output logic                     regs_wen_o,
  output logic [REG_AW-1:0]        rd_addr_o,
  output logic [XLEN-1:0]          rd_data_o,
  output logic                     busy_o
`ifdef WB_FWD_EN
  ,
  output logic                     fwd_valid_o,
  output logic [REG_AW-1:0]        fwd_addr_o,
  output logic [XLEN-1:0]          fwd_data_o
`endif
);

  localparam int PW = wb_ptr_width(NUM_CH);

  logic [NUM_CH-1:0] r_hold_vld;
  logic [REG_AW-1:0] r_hold_addr [NUM_CH];
  logic [XLEN-1:0]   r_hold_data [NUM_CH];
  logic [PW-1:0]     r_ptr;

  logic [NUM_CH-1:0] w_grant;
  logic [NUM_CH-1:0] w_accept;
  logic [PW-1:0]     w_next_ptr;
  logic [REG_AW-1:0] w_sel_addr;
  logic [XLEN-1:0]   w_sel_data;

  rr_arb #(
    .NUM_CH (NUM_CH),
    .PW     (PW)
  ) u_rr_arb (
    .i_req      (r_hold_vld),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_next_ptr (w_next_ptr)
  );

  // A buffer being drained this cycle can take a new result at the same edge
  assign ch_ready_o = ~r_hold_vld | w_grant;
  assign w_accept   = ch_valid_i & ch_ready_o;
  assign busy_o     = |r_hold_vld;

  // Grant is one-hot, so an OR-reduction mux selects the winning buffer
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_grant[k]) begin
        w_sel_addr = w_sel_addr | r_hold_addr[k];
        w_sel_data = w_sel_data | r_hold_data[k];
      end
    end
  end

  // Holding buffers. A result for x0 completes its handshake but is never
  // loaded, so it can never reach the write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_vld <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_hold_addr[k] <= '0;
        r_hold_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_accept[k] && (ch_rd_addr_i[k*REG_AW +: REG_AW] != '0)) begin
          r_hold_vld[k]  <= 1'b1;
          r_hold_addr[k] <= ch_rd_addr_i[k*REG_AW +: REG_AW];
          r_hold_data[k] <= ch_rd_data_i[k*XLEN +: XLEN];
        end else if (w_grant[k]) begin
          r_hold_vld[k]  <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer and registered write port. Address/data keep their
  // last value on idle cycles; only the enable drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      regs_wen_o <= 1'b0;
      rd_addr_o  <= '0;
      rd_data_o  <= '0;
    end else begin
      r_ptr      <= w_next_ptr;
      regs_wen_o <= |w_grant;
      if (|w_grant) begin
        rd_addr_o <= w_sel_addr;
        rd_data_o <= w_sel_data;
      end
    end
  end

`ifdef WB_FWD_EN
  // Bypass view of the value being written to the register file this cycle
  assign fwd_valid_o = regs_wen_o;
  assign fwd_addr_o  = rd_addr_o;
  assign fwd_data_o  = rd_data_o;
`endif

endmodule : wb_arb
`default_nettype wire

// File: tb/tb_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arb
// Description : Directed self-checking bench for wb_arb (NUM_CH=2, XLEN=32,
//               REG_AW=5). Inputs change 1 time unit after the rising edge;
//               outputs are sampled there as well.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ch_valid;
  logic [1:0]  ch_ready;
  logic [9:0]  ch_addr;
  logic [63:0] ch_data;
  logic        wen;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        busy;
`ifdef WB_FWD_EN
  logic        fv;
  logic [4:0]  fa;
  logic [31:0] fd;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Streaming scoreboard state
  int          sent0, sent1, wr0, wr1, cyc, wait1, max_wait1;
  logic        v1, acc0, acc1;
  logic [31:0] d1;
  logic [36:0] q0[$];
  logic [36:0] q1[$];
  logic [36:0] e;
  logic [4:0]  last_a;
  logic [31:0] last_d;

  always #5 clk = ~clk;

  wb_arb #(
    .NUM_CH (2),
    .XLEN   (32),
    .REG_AW (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ch_valid_i   (ch_valid),
    .ch_ready_o   (ch_ready),
    .ch_rd_addr_i (ch_addr),
    .ch_rd_data_i (ch_data),
    .regs_wen_o   (wen),
    .rd_addr_o    (rd_addr),
    .rd_data_o    (rd_data),
    .busy_o       (busy)
`ifdef WB_FWD_EN
    ,
    .fwd_valid_o  (fv),
    .fwd_addr_o   (fa),
    .fwd_data_o   (fd)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_wen, input logic [4:0] e_addr,
                         input logic [31:0] e_data);
    chk({tag, "_wen"},  {63'd0, wen}, {63'd0, e_wen});
    chk({tag, "_addr"}, {59'd0, rd_addr}, {59'd0, e_addr});
    chk({tag, "_data"}, {32'd0, rd_data}, {32'd0, e_data});
`ifdef WB_FWD_EN
    chk({tag, "_fwd_valid"}, {63'd0, fv}, {63'd0, e_wen});
    chk({tag, "_fwd_addr"},  {59'd0, fa}, {59'd0, e_addr});
    chk({tag, "_fwd_data"},  {32'd0, fd}, {32'd0, e_data});
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1i, input logic [4:0] a1, input logic [31:0] d1i);
    ch_valid = {v1i, v0};
    ch_addr  = {a1, a0};
    ch_data  = {d1i, d0};
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    #2;
    // ---- reset state
    chk_out("reset", 0, 5'd0, 32'd0);
    chk("reset_ready", 64'(ch_ready), 64'd3);
    chk("reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // ---- single write on ch0: enable 2 cycles after valid
    drive(1, 5'd5, 32'h1234, 0, 0, 0);
    chk("t1_ready_pre", 64'(ch_ready), 64'd3);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk_out("t1_e0", 0, 5'd0, 32'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_ready_held", 64'(ch_ready), 64'd3);
    tick();
    chk_out("t1_e1", 1, 5'd5, 32'h1234);
    chk("t1_busy_done", 64'(busy), 64'd0);
    tick();
    chk_out("t1_idle", 0, 5'd5, 32'h1234);

    // ---- single write on ch1 brings ptr back to 0
    drive(0, 0, 0, 1, 5'd7, 32'h77);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk_out("t1b_ch1", 1, 5'd7, 32'h77);
    tick();

    // ---- contention with ptr=0: ch0 first, ch1 waits one cycle
    drive(1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("t2_ready_ch1_low", 64'(ch_ready), 64'd1);
    chk("t2_busy", 64'(busy), 64'd1);
    chk_out("t2_c0", 0, 5'd7, 32'h77);
    tick();
    chk_out("t2_c1", 1, 5'd3, 32'h33);
    chk("t2_ready_back", 64'(ch_ready), 64'd3);
    tick();
    chk_out("t2_c2", 1, 5'd4, 32'h44);
    chk("t2_busy_done", 64'(busy), 64'd0);
    tick();
    chk_out("t2_c3", 0, 5'd4, 32'h44);
    // ptr must be back at 0: a second tie again goes to ch0 first
    drive(1, 5'd9, 32'h99, 1, 5'd10, 32'hAA);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk_out("t2_ptr_first", 1, 5'd9, 32'h99);
    tick();
    chk_out("t2_ptr_second", 1, 5'd10, 32'hAA);
    tick();

    // ---- ch0 streams 100 results, ch1 injects occasional results
    sent0 = 0; sent1 = 0; wr0 = 0; wr1 = 0; cyc = 0; wait1 = 0; max_wait1 = 0;
    v1 = 1'b0; d1 = 32'd0; last_a = 5'd10; last_d = 32'hAA;
    while ((sent0 < 100 || v1 || q0.size() != 0 || q1.size() != 0) && cyc < 2000) begin
      if (!v1 && sent1 < 8 && (cyc % 10) == 3) begin
        v1 = 1'b1;
        d1 = 32'hB000_0000 + 32'(sent1);
      end
      drive(sent0 < 100, 5'(1 + sent0 % 15), 32'hA000_0000 + 32'(sent0), v1, 5'd20, d1);
      #1;
      acc0 = ch_valid[0] & ch_ready[0];
      acc1 = ch_valid[1] & ch_ready[1];
      if (acc0) q0.push_back({ch_addr[4:0], ch_data[31:0]});
      if (acc1) q1.push_back({5'd20, d1});
      if (!ch_ready[1]) begin
        wait1++;
        if (wait1 > max_wait1) max_wait1 = wait1;
      end else begin
        wait1 = 0;
      end
      tick();
      if (wen) begin
        if (rd_data[31:28] == 4'hA) begin
          wr0++;
          chk("stream_q0_nonempty", 64'(q0.size() != 0), 64'd1);
          if (q0.size() != 0) begin
            e = q0.pop_front();
            chk("stream_ch0_addr", 64'(rd_addr), 64'(e[36:32]));
            chk("stream_ch0_data", 64'(rd_data), 64'(e[31:0]));
            last_a = e[36:32]; last_d = e[31:0];
          end
        end else begin
          wr1++;
          chk("stream_q1_nonempty", 64'(q1.size() != 0), 64'd1);
          if (q1.size() != 0) begin
            e = q1.pop_front();
            chk("stream_ch1_addr", 64'(rd_addr), 64'(e[36:32]));
            chk("stream_ch1_data", 64'(rd_data), 64'(e[31:0]));
            last_a = e[36:32]; last_d = e[31:0];
          end
        end
      end
      if (acc0) sent0++;
      if (acc1) begin
        sent1++;
        v1 = 1'b0;
      end
      cyc++;
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("stream_no_timeout", 64'(cyc < 2000), 64'd1);
    chk("stream_ch0_count", 64'(wr0), 64'd100);
    chk("stream_ch1_count", 64'(wr1), 64'(sent1));
    chk("stream_ch1_sent", 64'(sent1 > 0), 64'd1);
    chk("stream_ch1_wait", 64'(max_wait1 <= 1), 64'd1);
    tick();
    chk_out("stream_idle", 0, last_a, last_d);

    // ---- write to x0: accepted, never written, never buffered
    drive(0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF);
    chk("t4_ready", 64'(ch_ready[1]), 64'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("t4_busy0", 64'(busy), 64'd0);
    chk_out("t4_c0", 0, last_a, last_d);
    tick();
    chk("t4_busy1", 64'(busy), 64'd0);
    chk_out("t4_c1", 0, last_a, last_d);
    tick();
    chk_out("t4_c2", 0, last_a, last_d);

    // ---- reset while both buffers are valid (ptr=1 beforehand)
    drive(1, 5'd13, 32'hDD, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk_out("t5_pre", 1, 5'd13, 32'hDD);
    tick();
    drive(1, 5'd11, 32'hB1, 1, 5'd12, 32'hC1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("t5_busy_loaded", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_busy_async", 64'(busy), 64'd0);
    chk("t5_ready_async", 64'(ch_ready), 64'd3);
    chk_out("t5_async", 0, 5'd0, 32'd0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_out("t5_rel0", 0, 5'd0, 32'd0);
    tick();
    chk_out("t5_rel1", 0, 5'd0, 32'd0);
    chk("t5_busy_rel", 64'(busy), 64'd0);
    // ptr must be 0 after reset: tie goes to ch0 first
    drive(1, 5'd14, 32'hE0, 1, 5'd15, 32'hF0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk_out("t5_ptr_first", 1, 5'd14, 32'hE0);
    tick();
    chk_out("t5_ptr_second", 1, 5'd15, 32'hF0);
    tick();
    chk_out("t5_end", 0, 5'd15, 32'hF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_wb_arb
`default_nettype wire
